// File: rtl/period_meter_pkg.sv
// rtl/period_meter_pkg.sv - shared types and defaults for the clock period meter
package period_meter_pkg;

  localparam int DefCntW = 26;

  typedef enum logic {
    IDLE    = 1'b0,
    MEASURE = 1'b1
  } state_e;

endpackage

// File: rtl/clk_period_meter_if.sv
// rtl/clk_period_meter_if.sv - measured input and result bundle of the period meter
interface clk_period_meter_if #(
  parameter int CntW = period_meter_pkg::DefCntW
);

  logic            SigIn;
  logic [CntW-1:0] Period;
  logic            Valid;
  logic            Locked;
  logic            Timeout;
  logic [CntW-1:0] HighTime;

  modport master (
    input  SigIn,
    output Period, Valid, Locked, Timeout, HighTime
  );

  modport slave (
    output SigIn,
    input  Period, Valid, Locked, Timeout, HighTime
  );

endinterface

// File: rtl/sig_sync_edge.sv
// rtl/sig_sync_edge.sv - two-flop synchroniser with a registered copy and rising-edge detect
module sig_sync_edge (
  input  logic Clk,
  input  logic Rst,
  input  logic In,
  output logic Level,
  output logic Rise
);

  logic s1, s2, s3;

  always_ff @(posedge Clk) begin
    if (Rst) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= In;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign Level = s3;
  assign Rise  = s2 & ~s3;

endmodule

// File: rtl/clk_period_meter.sv
// rtl/clk_period_meter.sv - edge-to-edge period meter with timeout; PERIOD_METER_DUTY_EN adds high-time
module clk_period_meter
  import period_meter_pkg::*;
#(
  parameter int CntW   = DefCntW,
  parameter int MaxCnt = 2**CntW - 1
) (
  input  logic                Clk,
  input  logic                Rst,
  clk_period_meter_if.master  io
);

  localparam logic [CntW-1:0] MaxCntV = CntW'(MaxCnt);
  localparam logic [CntW-1:0] One     = CntW'(1);

  state_e          state_q, state_d;
  logic [CntW-1:0] count;
  logic [CntW-1:0] period_r;
  logic            valid_r;
  logic            timeout_r;
  logic            locked;
  logic            level;
  logic            rise;
  logic            at_max;

  sig_sync_edge u_sync (
    .Clk   (Clk),
    .Rst   (Rst),
    .In    (io.SigIn),
    .Level (level),
    .Rise  (rise)
  );

  assign at_max = (count == MaxCntV);

  always_comb begin
    state_d = state_q;
    locked  = 1'b0;
    case (state_q)
      IDLE: begin
        if (rise) state_d = MEASURE;
      end
      MEASURE: begin
        locked = 1'b1;
        // an edge landing on the threshold cycle still counts as a measurement
        if (!rise && at_max) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q   <= IDLE;
      count     <= '0;
      period_r  <= '0;
      valid_r   <= 1'b0;
      timeout_r <= 1'b0;
    end else begin
      state_q <= state_d;
      valid_r <= 1'b0;
      case (state_q)
        IDLE: begin
          count <= rise ? One : '0;
        end
        MEASURE: begin
          if (rise) begin
            period_r  <= count;
            valid_r   <= 1'b1;
            timeout_r <= 1'b0;
            count     <= One;
          end else if (at_max) begin
            timeout_r <= 1'b1;
            count     <= '0;
          end else begin
            count <= count + One;
          end
        end
        default: count <= '0;
      endcase
    end
  end

`ifdef PERIOD_METER_DUTY_EN
  logic [CntW-1:0] hi_count;
  logic [CntW-1:0] high_r;

  // Level lags Rise by one cycle, so restarting at zero on the edge and counting
  // Level-high cycles yields exactly the synchronised high duration of the period.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      hi_count <= '0;
      high_r   <= '0;
    end else begin
      case (state_q)
        IDLE: hi_count <= '0;
        MEASURE: begin
          if (rise) begin
            high_r   <= hi_count;
            hi_count <= '0;
          end else if (at_max) begin
            hi_count <= '0;
          end else if (level) begin
            hi_count <= hi_count + One;
          end
        end
        default: hi_count <= '0;
      endcase
    end
  end

  assign io.HighTime = high_r;
`else
  logic unused_level;
  assign unused_level = level;
  assign io.HighTime  = '0;
`endif

  assign io.Period  = period_r;
  assign io.Valid   = valid_r;
  assign io.Locked  = locked;
  assign io.Timeout = timeout_r;

endmodule
